// File: rtl/axi_read_arbiter_pkg.sv
// Shared types and constants for the two-port AXI4-Lite read arbiter.
package axi_arb_pkg;

  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_DATA_W = 32;

  // Transaction sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  // Index of a requesting port (0 = instruction cache, 1 = load path).
  typedef logic port_idx_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

endpackage

// File: rtl/axi_read_arbiter_if.sv
// AXI4-Lite read channel (AR + R) bundle; master drives requests, slave responds.
interface axi_read_arbiter_if
  import axi_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = AXI_ADDR_W,
  parameter int unsigned DATA_W = AXI_DATA_W
);

  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;

  modport master (
    output arvalid, araddr, arprot, rready,
    input  arready, rvalid, rdata, rresp
  );

  modport slave (
    input  arvalid, araddr, arprot, rready,
    output arready, rvalid, rdata, rresp
  );

endinterface

// File: rtl/axi_read_arbiter_arb_pick.sv
// Grant selection between the two read ports.
// Optional feature: define AXI_ARB_ROUND_ROBIN_EN for round-robin tie breaking;
// otherwise port 0 wins every tie (fixed priority).
module arb_pick
  import axi_arb_pkg::*;
(
  input  logic      req0,
  input  logic      req1,
  input  port_idx_t last_grant,
  output logic      grant_valid,
  output port_idx_t grant_idx
);

`ifdef AXI_ARB_ROUND_ROBIN_EN
  // Tie goes to the port that did not win last; a lone requester always wins.
  always_comb begin
    grant_valid = req0 | req1;
    grant_idx   = 1'b0;
    if (req0 && req1) begin
      grant_idx = ~last_grant;
    end else if (req1) begin
      grant_idx = 1'b1;
    end
  end
`else
  // Fixed priority: port 0 wins whenever it requests; history is ignored.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    grant_valid = req0 | req1;
    grant_idx   = 1'b0;
    if (!req0 && req1) begin
      grant_idx = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI4-Lite read channel between two masters, one transaction at a
// time. Tie-break policy lives in arb_pick (macro AXI_ARB_ROUND_ROBIN_EN).
module axi_read_arbiter
  import axi_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = AXI_ADDR_W,
  parameter int unsigned DATA_W = AXI_DATA_W
) (
  input  logic                 clk,
  input  logic                 reset,
  axi_read_arbiter_if.slave    s0,
  axi_read_arbiter_if.slave    s1,
  axi_read_arbiter_if.master   m,
  output logic                 busy,
  output port_idx_t            owner
);

  arb_state_e        state_q;
  arb_state_e        state_d;
  logic              grant_valid;
  port_idx_t         grant_idx;
  port_idx_t         owner_q;
  port_idx_t         last_grant_q;
  logic              m_arvalid_q;
  logic [ADDR_W-1:0] m_araddr_q;
  logic [2:0]        m_arprot_q;
  logic              owner_rready;
  logic              ar_hs;
  logic              r_hs;

  // Grant decision from the request lines only (no memory-side inputs).
  arb_pick u_pick (
    .req0        (s0.arvalid),
    .req1        (s1.arvalid),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign owner_rready = (owner_q == 1'b1) ? s1.rready : s0.rready;
  assign ar_hs        = m_arvalid_q && m.arready;
  assign r_hs         = (state_q == DATA) && m.rvalid && owner_rready;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and combinational handshake outputs.
  always_comb begin
    state_d    = state_q;
    s0.arready = 1'b0;
    s1.arready = 1'b0;
    s0.rvalid  = 1'b0;
    s1.rvalid  = 1'b0;
    m.rready   = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          s0.arready = (grant_idx == 1'b0);
          s1.arready = (grant_idx == 1'b1);
          state_d    = ADDR;
        end
      end
      ADDR: begin
        if (ar_hs) begin
          state_d = DATA;
        end
      end
      DATA: begin
        s0.rvalid = m.rvalid && (owner_q == 1'b0);
        s1.rvalid = m.rvalid && (owner_q == 1'b1);
        m.rready  = owner_rready;
        if (r_hs) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Memory-side request registers, ownership and grant history.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_arvalid_q  <= 1'b0;
      m_araddr_q   <= '0;
      m_arprot_q   <= 3'b000;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            m_arvalid_q <= 1'b1;
            m_araddr_q  <= (grant_idx == 1'b1) ? s1.araddr : s0.araddr;
            m_arprot_q  <= (grant_idx == 1'b1) ? s1.arprot : s0.arprot;
            owner_q     <= grant_idx;
          end
        end
        ADDR: begin
          if (ar_hs) begin
            m_arvalid_q <= 1'b0;
          end
        end
        DATA: begin
          if (r_hs) begin
            last_grant_q <= owner_q;
          end
        end
        default: begin
          m_arvalid_q <= 1'b0;
        end
      endcase
    end
  end

  assign m.arvalid = m_arvalid_q;
  assign m.araddr  = m_araddr_q;
  assign m.arprot  = m_arprot_q;

  // Read data and response are broadcast; only the owner sees rvalid.
  assign s0.rdata = m.rdata;
  assign s1.rdata = m.rdata;
  assign s0.rresp = m.rresp;
  assign s1.rresp = m.rresp;

  assign busy  = (state_q != IDLE);
  assign owner = owner_q;

endmodule
